display_arbiter: RTL

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
//
// Shares one hex seven-segment converter between four requesters. A
// round-robin arbiter grants one requester at a time and captures its byte.
// It then issues a one-cycle capture strobe with a matching acknowledge. A
// dwell period follows so that each value stays on the display long enough to
// be read.
//
// Grant sequence:  IDLE --(req != 0)--> PULSE --> HOLD (DWELL_CYCLES) --> IDLE
//
// Parameters
//   DWELL_CYCLES  length of HOLD in clk cycles (values below 1 act as 1)
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req[3:0]    in   level request, bit i = requester i
//   data_in[31:0] in requester bytes, requester i on [8i+7:8i]
//   ack[3:0]    out  one-cycle acknowledge to the granted requester
//   update      out  capture strobe toward the seven-segment converter
//   data[7:0]   out  byte presented to the converter
//   active_src  out  index of the last granted requester
//   busy        out  high while a grant is in progress (PULSE or HOLD)
//
// Build option
//   DISPLAY_ARB_SRCTAG_EN  when defined, data[7:4] shows the winner index and
//                          data[3:0] shows the low nibble of its byte. When
//                          undefined, data carries the full winner byte.
// -----------------------------------------------------------------------------
module display_arbiter #(
    parameter int DWELL_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] data_in,
    output logic [3:0]  ack,
    output logic        update,
    output logic [7:0]  data,
    output logic [1:0]  active_src,
    output logic        busy
);

    // Clamp the dwell length. One extra counter bit above the terminal count
    // is not needed, but the width still covers DWELL_EFF itself.
    localparam int DWELL_EFF = (DWELL_CYCLES < 1) ? 1 : DWELL_CYCLES;
    localparam int CNT_W     = $clog2(DWELL_EFF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_EFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       data_reg, data_next;
    logic [1:0]       active_src_reg, active_src_next;
    logic [1:0]       last_src_reg, last_src_next;

    // -------------------------------------------------------------------------
    // Round-robin winner search
    // Candidate k is requester (last_src + 1 + k) mod 4. The 2-bit add wraps
    // 3 -> 0 on its own. The lowest k that has req set wins.
    // -------------------------------------------------------------------------
    logic [1:0] cand_idx [4];
    logic [3:0] cand_hit;
    logic [1:0] win_idx;
    logic       any_req;

    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
        assign cand_idx[gi] = last_src_reg + 2'(gi + 1);
        assign cand_hit[gi] = req[cand_idx[gi]];
    end

    assign any_req = |req;

    always_comb begin
        win_idx = cand_idx[3];
        for (int k = 3; k >= 0; k--) begin
            if (cand_hit[k]) begin
                win_idx = cand_idx[k];
            end
        end
    end

    // Byte that will be presented if the current winner is captured this edge.
    logic [7:0] win_data;

`ifdef DISPLAY_ARB_SRCTAG_EN
    logic [3:0] win_nibble;
    assign win_nibble = data_in[{win_idx, 3'b000} +: 4];
    assign win_data   = {2'b00, win_idx, win_nibble};
`else
    assign win_data   = data_in[{win_idx, 3'b000} +: 8];
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = ST_PULSE;
                end
            end
            ST_PULSE: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next values
    // data and the source registers only change on the capture edge.
    // Requests and data_in are therefore ignored outside IDLE.
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_next        = cnt_reg;
        data_next       = data_reg;
        active_src_next = active_src_reg;
        last_src_next   = last_src_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    data_next       = win_data;
                    active_src_next = win_idx;
                    last_src_next   = win_idx;
                end
            end
            ST_PULSE: begin
                cnt_next = '0;
            end
            ST_HOLD: begin
                // Saturate at the terminal count. The counter never wraps
                // while HOLD is active.
                if (cnt_reg != CNT_LAST) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                cnt_next = '0;
            end
        endcase
    end

    // last_src resets to 3 so that the first search after reset starts at
    // requester 0. active_src resets to 0 for the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            data_reg       <= 8'h00;
            active_src_reg <= 2'd0;
            last_src_reg   <= 2'd3;
        end else begin
            cnt_reg        <= cnt_next;
            data_reg       <= data_next;
            active_src_reg <= active_src_next;
            last_src_reg   <= last_src_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // The outputs are decoded from the state register. Because reset clears
    // the state register asynchronously, update, ack and busy also drop
    // without a clock. During PULSE, active_src_reg already holds the winner.
    // -------------------------------------------------------------------------
    logic pulse_now;

    always_comb begin
        pulse_now = (state_reg == ST_PULSE);
        update    = pulse_now;
        busy      = (state_reg != ST_IDLE);
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_ack
        assign ack[gi] = pulse_now && (active_src_reg == 2'(gi));
    end

    assign data       = data_reg;
    assign active_src = active_src_reg;

endmodule
